// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: four-digit multiplexed 7-segment scan controller.
// Each digit is driven for DIV cycles, followed by GAP all-off blanking
// cycles to suppress ghosting. A new display value is parked in a pending
// register and only copied into the displayed shadow at a frame boundary
// (or while idle), so a single frame never mixes two values.
module disp_scan_ctrl #(
    parameter int unsigned DIV = 12500,
    parameter int unsigned GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic        load_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [13:0] DIV_LAST = 14'(DIV - 1);
    localparam logic [13:0] GAP_LAST = 14'(GAP - 1);

    // Scan state and datapath registers
    state_t      state;
    state_t      state_nxt;
    logic [13:0] cnt;
    logic [13:0] cnt_nxt;
    logic [1:0]  dig;
    logic [1:0]  dig_nxt;
    logic [15:0] shadow;
    logic [15:0] shadow_nxt;
    logic [3:0]  shadow_dp;
    logic [3:0]  shadow_dp_nxt;
    logic [15:0] pend;
    logic [15:0] pend_nxt;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_dp_nxt;
    logic        pend_v;
    logic        pend_v_nxt;

    // Handshake / transfer qualifiers
    logic        frame_end;
    logic        xfer;
    logic        accept;

    // Next values of the registered outputs
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic        frame_done_nxt;
    logic        load_ready_nxt;
    logic [3:0]  nib_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // State register plus counters, shadow and pending storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OFF;
            cnt       <= '0;
            dig       <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            pend      <= '0;
            pend_dp   <= '0;
            pend_v    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dig       <= dig_nxt;
            shadow    <= shadow_nxt;
            shadow_dp <= shadow_dp_nxt;
            pend      <= pend_nxt;
            pend_dp   <= pend_dp_nxt;
            pend_v    <= pend_v_nxt;
        end
    end

    // Next-state logic: scan sequencing and pending/shadow handover
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dig_nxt   = dig;
        frame_end = 1'b0;

        case (state)
            S_OFF: begin
                cnt_nxt = '0;
                dig_nxt = '0;
                if (en) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!en) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                    dig_nxt   = '0;
                end else if (cnt == DIV_LAST) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 14'd1;
                end
            end
            S_GAP: begin
                if (!en) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                    dig_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = '0;
                    dig_nxt   = dig + 2'd1;
                    frame_end = (dig == 2'd3);
                end else begin
                    cnt_nxt = cnt + 14'd1;
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
                dig_nxt   = '0;
            end
        endcase

        // Transfer happens on the edge that starts the new frame, so digit 0
        // of that frame already shows the new value; accept and transfer are
        // mutually exclusive because one needs pend_v=0 and the other pend_v=1.
        xfer   = pend_v && (frame_end || (state == S_OFF));
        accept = load_valid && !pend_v;

        shadow_nxt    = shadow;
        shadow_dp_nxt = shadow_dp;
        pend_nxt      = pend;
        pend_dp_nxt   = pend_dp;
        pend_v_nxt    = pend_v;

        if (xfer) begin
            shadow_nxt    = pend;
            shadow_dp_nxt = pend_dp;
            pend_v_nxt    = 1'b0;
        end else if (accept) begin
            pend_nxt    = load_data;
            pend_dp_nxt = load_dp;
            pend_v_nxt  = 1'b1;
        end
    end

    // Output logic: derive output values from the upcoming state so the
    // registered outputs line up with the state they describe
    always_comb begin
        nib_nxt        = shadow_nxt[{dig_nxt, 2'b00} +: 4];
        an_nxt         = 4'b1111;
        seg_nxt        = 7'h7F;
        dp_nxt         = 1'b1;
        frame_done_nxt = frame_end;
        load_ready_nxt = !pend_v_nxt;

        if (state_nxt == S_DRIVE) begin
            an_nxt  = ~(4'b0001 << dig_nxt);
            seg_nxt = hex_to_seg(nib_nxt);
            dp_nxt  = ~shadow_dp_nxt[dig_nxt];
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
            load_ready <= load_ready_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed self-checking bench for disp_scan_ctrl with
// DIV=4, GAP=2 (6 cycles per digit slot, 24 cycles per frame).
module tb_disp_scan_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        load_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    disp_scan_ctrl #(
        .DIV(DIV),
        .GAP(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected display for cycle i of a scan that started at i=0 with digit 0
    task automatic chk_scan(input string tag, input int i, input logic [15:0] val,
                            input logic [3:0] dpv, input logic fd_exp);
        int         pos;
        int         d;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic [3:0] nib;
        pos = i % 6;
        d   = (i / 6) % 4;
        if (pos < 4) begin
            an_e  = ~(4'b0001 << d);
            nib   = val[4*d +: 4];
            seg_e = exp_seg(nib);
            dp_e  = ~dpv[d];
        end else begin
            an_e  = 4'b1111;
            seg_e = 7'h7F;
            dp_e  = 1'b1;
        end
        chk($sformatf("%s_an_%0d", tag, i), 32'(an), 32'(an_e));
        chk($sformatf("%s_seg_%0d", tag, i), 32'(seg), 32'(seg_e));
        chk($sformatf("%s_dp_%0d", tag, i), 32'(dp), 32'(dp_e));
        chk($sformatf("%s_fd_%0d", tag, i), 32'(frame_done), 32'(fd_exp));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"},  32'(an), 32'h0000_000F);
        chk({tag, "_seg"}, 32'(seg), 32'h0000_007F);
        chk({tag, "_dp"},  32'(dp), 32'h1);
        chk({tag, "_fd"},  32'(frame_done), 32'h0);
        chk({tag, "_rdy"}, 32'(load_ready), 32'h1);
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  vdp;
        logic        rdy_e;

        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_dp    = 4'h0;

        // Reset state
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // Idle scan with zero shadow: every digit shows 0, frame_done at 24
        en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            chk_scan("idle", i, 16'h0000, 4'h0, (i == 24));
            chk($sformatf("idle_rdy_%0d", i), 32'(load_ready), 32'h1);
        end
        en = 1'b0;
        tick();
        chk("off_an", 32'(an), 32'h0000_000F);
        chk("off_fd", 32'(frame_done), 32'h0);

        // Load while OFF: accepted, then transferred on the next OFF cycle
        load_data  = 16'h8F21;
        load_dp    = 4'b0100;
        load_valid = 1'b1;
        tick();
        chk("off_acc_rdy", 32'(load_ready), 32'h0);
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_dp    = 4'h0;
        tick();
        chk("off_xfer_rdy", 32'(load_ready), 32'h1);
        chk("off_xfer_an", 32'(an), 32'h0000_000F);

        // Three frames: 8F21, then mid-frame load 1111, then held load 2345
        en = 1'b1;
        for (int i = 0; i < 62; i++) begin
            tick();
            if (i < 24) begin
                v = 16'h8F21; vdp = 4'b0100;
            end else if (i < 48) begin
                v = 16'h1111; vdp = 4'b0000;
            end else begin
                v = 16'h2345; vdp = 4'b0001;
            end
            chk_scan("scan", i, v, vdp, (i == 24) || (i == 48));
            rdy_e = (i < 9) || (i == 24) || (i >= 48);
            chk($sformatf("scan_rdy_%0d", i), 32'(load_ready), 32'(rdy_e));
            if (i == 8) begin
                load_valid = 1'b1;
                load_data  = 16'h1111;
                load_dp    = 4'b0000;
            end
            if (i == 9) begin
                load_data = 16'h2345;
                load_dp   = 4'b0001;
            end
            if (i == 25) begin
                load_valid = 1'b0;
                load_data  = 16'h0000;
                load_dp    = 4'h0;
            end
            if (i == 61) begin
                en = 1'b0;
            end
        end

        // en dropped during digit 2 drive: blank next cycle, restart at digit 0
        tick();
        chk("stop_an", 32'(an), 32'h0000_000F);
        chk("stop_seg", 32'(seg), 32'h0000_007F);
        chk("stop_fd", 32'(frame_done), 32'h0);
        en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_scan("restart", j, 16'h2345, 4'b0001, 1'b0);
            chk($sformatf("restart_rdy_%0d", j), 32'(load_ready), 32'h1);
        end

        // Reset mid-drive with a pending value: pending must be discarded
        load_valid = 1'b1;
        load_data  = 16'h7777;
        load_dp    = 4'hF;
        tick();
        chk("pend_rdy", 32'(load_ready), 32'h0);
        chk("pend_an", 32'(an), 32'h0000_000D);
        load_valid = 1'b0;
        rst        = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        tick();
        chk("post_rst_an", 32'(an), 32'h0000_000E);
        chk("post_rst_seg", 32'(seg), 32'h0000_0040);
        chk("post_rst_dp", 32'(dp), 32'h1);
        chk("post_rst_rdy", 32'(load_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
